// File: rtl/mmio_timer.sv
// ---------------------------------------------------------------------------
// mmio_timer
//   Memory-mapped timer on the core data bus (load/store responder side).
//   A prescaled 32-bit up-counter with a compare match, overflow detection
//   and sticky write-1-to-clear status flags. The top level muxes
//   Read_Data_o onto the load path whenever Hit_o is high.
//
//   Register window (16 bytes at BASE_ADDR, Address_i[1:0] ignored):
//     0x0 CTRL     [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [31:16] PRESCALE
//     0x4 COUNT    R/W, a write also clears the prescaler
//     0x8 COMPARE  R/W
//     0xC STATUS   [0] MATCH, [1] OVERFLOW (sticky, write-1-to-clear)
//
//   Optional feature macro: MMIO_TIMER_IRQ_EN
//     defined     -> Irq_o port present, registered IRQ_EN & (MATCH | OVERFLOW)
//     not defined -> no Irq_o port, CTRL[2] reads 0 and ignores writes
//
// Ports
//   clk           in   1   system clock, rising edge
//   reset         in   1   asynchronous active-high reset
//   Mem_Write_i   in   1   store strobe
//   Mem_Read_i    in   1   load strobe
//   Address_i     in   32  byte address
//   Write_Data_i  in   32  store data
//   Read_Data_o   out  32  load data, combinational, 0 when not selected
//   Hit_o         out  1   address falls inside the register window
//   Irq_o         out  1   interrupt request (MMIO_TIMER_IRQ_EN only)
// ---------------------------------------------------------------------------
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h1001_0100,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Write_i,
    input  logic        Mem_Read_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        Hit_o
`ifdef MMIO_TIMER_IRQ_EN
    ,
    output logic        Irq_o
`endif
);

    logic                      r_en;
    logic                      r_auto;
    logic                      r_irq_en;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [31:0]               r_count;
    logic [31:0]               r_compare;
    logic                      r_match;
    logic                      r_ovf;

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_cmp;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_cmp_eq;
    logic        w_set_match;
    logic        w_set_ovf;
    logic [31:0] w_ctrl;
    logic        w_unused_addr_bits;

    // Byte-lane bits of the address carry no information for word registers.
    assign w_unused_addr_bits = &{1'b0, Address_i[1:0]};

    assign w_hit       = (Address_i[31:4] == BASE_ADDR[31:4]);
    assign w_off       = Address_i[3:2];
    assign Hit_o       = w_hit;

    assign w_wr_ctrl   = Mem_Write_i && w_hit && (w_off == 2'd0);
    assign w_wr_count  = Mem_Write_i && w_hit && (w_off == 2'd1);
    assign w_wr_cmp    = Mem_Write_i && w_hit && (w_off == 2'd2);
    assign w_wr_status = Mem_Write_i && w_hit && (w_off == 2'd3);

    // Tick qualification uses the EN value before this edge, so a tick that
    // is already due survives a same-edge write of EN=0.
    assign w_tick   = r_en && (r_presc == r_prescale);
    assign w_cmp_eq = (r_count == r_compare);

    // A CPU store to COUNT discards the whole tick, flag updates included.
    assign w_set_match = w_tick && !w_wr_count && w_cmp_eq;
    assign w_set_ovf   = w_tick && !w_wr_count && !w_cmp_eq && (&r_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
        end else if (w_wr_ctrl) begin
            r_en       <= Write_Data_i[0];
            r_auto     <= Write_Data_i[1];
`ifdef MMIO_TIMER_IRQ_EN
            r_irq_en   <= Write_Data_i[2];
`else
            r_irq_en   <= 1'b0;
`endif
            r_prescale <= Write_Data_i[16 +: PRESCALE_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_wr_count) begin
            r_presc <= '0;
        end else if (r_en) begin
            r_presc <= w_tick ? '0 : r_presc + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= Write_Data_i;
        end else if (w_tick) begin
            if (w_cmp_eq) begin
                r_count <= r_auto ? 32'd0 : r_count + 32'd1;
            end else if (&r_count) begin
                r_count <= 32'd0;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_compare <= '0;
        end else if (w_wr_cmp) begin
            r_compare <= Write_Data_i;
        end
    end

    // Setting a flag wins over a same-edge write-1-to-clear of that flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_match <= w_set_match || (r_match && !(w_wr_status && Write_Data_i[0]));
            r_ovf   <= w_set_ovf   || (r_ovf   && !(w_wr_status && Write_Data_i[1]));
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    logic r_irq;

    // Registered from the flag registers: follows a flag change by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en && (r_match || r_ovf);
        end
    end

    assign Irq_o = r_irq;
`endif

    always_comb begin
        w_ctrl                         = 32'h0;
        w_ctrl[0]                      = r_en;
        w_ctrl[1]                      = r_auto;
        w_ctrl[2]                      = r_irq_en;
        w_ctrl[16 +: PRESCALE_WIDTH]   = r_prescale;
    end

    always_comb begin
        Read_Data_o = 32'h0;
        if (Mem_Read_i && w_hit) begin
            case (w_off)
                2'd0:    Read_Data_o = w_ctrl;
                2'd1:    Read_Data_o = r_count;
                2'd2:    Read_Data_o = r_compare;
                default: Read_Data_o = {30'h0, r_ovf, r_match};
            endcase
        end
    end

endmodule
